// File: rtl/integral_image_builder_if.sv
// Pixel stream and integral read port bundle.
// The master drives pixels and read requests. The slave returns integral values.
interface integral_image_builder_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] pixel_in;
  logic             pixel_valid;
  logic             pixel_ready;
  logic [4:0]       x_in;
  logic [4:0]       y_in;
  logic             rd_req;
  logic [95:0]      integral_buffer_out;
  logic             rd_valid;
  logic             rd_err;

  modport master (
    output pixel_in, pixel_valid, x_in, y_in, rd_req,
    input  pixel_ready, integral_buffer_out, rd_valid, rd_err
  );

  modport slave (
    input  pixel_in, pixel_valid, x_in, y_in, rd_req,
    output pixel_ready, integral_buffer_out, rd_valid, rd_err
  );
endinterface

// File: rtl/integral_image_builder.sv
// Builds a summed-area table from a raster pixel stream.
// The finished frame is served through a 1-cycle read port.
module integral_image_builder #(
  parameter int IMG_W = 20,
  parameter int IMG_H = 20,
  parameter int PIX_W = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic START,
  output logic frame_ready,
  integral_image_builder_if.slave bus
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = $clog2(NPIX);
  localparam int SUM_W = $clog2(NPIX * ((1 << PIX_W) - 1) + 1);
  localparam int CW    = 5;
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    READY
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    x_q;
  logic [CW-1:0]    y_q;
  logic [SUM_W-1:0] row_q;
  logic             pix_rdy_q;
  logic             rd_valid_q;
  logic             rd_err_q;
  logic             frame_q;
  logic [SUM_W-1:0] rd_data_q;

  logic [SUM_W-1:0] mem [NPIX];

  logic             accept;
  logic             x_last;
  logic             y_last;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [SUM_W-1:0] row_d;
  logic [SUM_W-1:0] above;
  logic [SUM_W-1:0] ii_d;
  logic             rd_ok;

  assign accept  = (state_q == BUILD) && bus.pixel_valid && !START;
  assign x_last  = (x_q == XMAX);
  assign y_last  = (y_q == YMAX);
  assign wr_addr = AW'(y_q) * AW'(IMG_W) + AW'(x_q);
  assign row_d   = row_q + SUM_W'(bus.pixel_in);

  // Previous row's entry in the same column is already stored.
  always_comb begin
    above = '0;
    if (y_q != '0) above = mem[wr_addr - AW'(IMG_W)];
  end

  assign ii_d    = row_d + above;
  assign rd_ok   = (state_q == READY) &&
                   (bus.x_in <= XMAX) &&
                   (bus.y_in <= YMAX);
  assign rd_addr = AW'(bus.y_in) * AW'(IMG_W) + AW'(bus.x_in);

  always_ff @(posedge Clk) begin
    if (accept) mem[wr_addr] <= ii_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      pix_rdy_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      frame_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req;
      rd_err_q   <= bus.rd_req && !rd_ok;
      rd_data_q  <= (bus.rd_req && rd_ok) ? mem[rd_addr] : '0;
      unique case (1'b1)
        START: begin
          state_q   <= BUILD;
          x_q       <= '0;
          y_q       <= '0;
          row_q     <= '0;
          pix_rdy_q <= 1'b1;
          frame_q   <= 1'b0;
        end
        accept: begin
          row_q <= x_last ? '0 : row_d;
          x_q   <= x_last ? '0 : x_q + 1'b1;
          y_q   <= x_last ? y_q + 1'b1 : y_q;
          if (x_last && y_last) begin
            state_q   <= READY;
            y_q       <= '0;
            pix_rdy_q <= 1'b0;
            frame_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign frame_ready             = frame_q;
  assign bus.pixel_ready         = pix_rdy_q;
  assign bus.rd_valid            = rd_valid_q;
  assign bus.rd_err              = rd_err_q;
  assign bus.integral_buffer_out = 96'(rd_data_q);
endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder.
// Reads are scoreboarded and checked when rd_valid returns.
module tb_integral_image_builder;
  logic Clk;
  logic Reset_n;
  logic START;
  logic frame_ready;

  integral_image_builder_if #(.PIX_W(8)) bus ();

  integral_image_builder #(
    .IMG_W(20),
    .IMG_H(20),
    .PIX_W(8)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .START      (START),
    .frame_ready(frame_ready),
    .bus        (bus)
  );

  typedef struct {
    int          due;
    logic [95:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   ref_ii [20][20];
  logic exp_v;
  exp_t e;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc++;

  task automatic check(input string tag,
                       input logic [95:0] got,
                       input logic [95:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    check("rd_valid", 96'(bus.rd_valid), 96'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      check("rd_data", bus.integral_buffer_out, e.data);
      check("rd_err", 96'(bus.rd_err), 96'(e.err));
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd(input int x, input int y,
                    input int d, input logic er);
    exp_t t;
    bus.x_in   = 5'(x);
    bus.y_in   = 5'(y);
    bus.rd_req = 1'b1;
    t.due  = cyc + 1;
    t.data = 96'(d);
    t.err  = er;
    q.push_back(t);
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic feed(input int n, input bit ramp,
                      input int val, input bit gaps);
    int px;
    int py;
    px = 0;
    py = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pixel_valid = 1'b0;
        step();
      end
      bus.pixel_in    = ramp ? 8'(px + py) : 8'(val);
      bus.pixel_valid = 1'b1;
      step();
      px++;
      if (px == 20) begin
        px = 0;
        py++;
      end
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_pix_rdy"}, 96'(bus.pixel_ready), 96'(0));
    check({tag, "_rd_valid"}, 96'(bus.rd_valid), 96'(0));
    check({tag, "_rd_err"}, 96'(bus.rd_err), 96'(0));
    check({tag, "_frame"}, 96'(frame_ready), 96'(0));
    check({tag, "_data"}, bus.integral_buffer_out, 96'(0));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++) begin
        ref_ii[y][x] = 0;
        for (int j = 0; j <= y; j++)
          for (int i = 0; i <= x; i++)
            ref_ii[y][x] += i + j;
      end

    Reset_n         = 1'b0;
    START           = 1'b0;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.x_in        = '0;
    bus.y_in        = '0;
    bus.rd_req      = 1'b0;
    repeat (3) step();
    check_outs_zero("reset");
    Reset_n = 1'b1;
    step();

    rd(3, 3, 0, 1'b1);
    rd(0, 0, 0, 1'b1);

    start();
    check("build_pix_rdy", 96'(bus.pixel_ready), 96'(1));
    feed(400, 1'b0, 1, 1'b0);
    check("ones_frame", 96'(frame_ready), 96'(1));
    check("ready_pix_rdy", 96'(bus.pixel_ready), 96'(0));
    rd(0, 0, 1, 1'b0);
    rd(4, 2, 15, 1'b0);
    rd(19, 19, 400, 1'b0);
    rd(20, 3, 0, 1'b1);
    rd(3, 20, 0, 1'b1);

    feed(5, 1'b0, 9, 1'b0);
    rd(19, 19, 400, 1'b0);

    START           = 1'b1;
    bus.x_in        = 5'd4;
    bus.y_in        = 5'd2;
    bus.rd_req      = 1'b1;
    e.due  = cyc + 1;
    e.data = 96'd15;
    e.err  = 1'b0;
    q.push_back(e);
    step();
    START      = 1'b0;
    bus.rd_req = 1'b0;
    check("restart_frame", 96'(frame_ready), 96'(0));
    check("restart_pix_rdy", 96'(bus.pixel_ready), 96'(1));

    feed(400, 1'b0, 255, 1'b0);
    rd(19, 19, 102000, 1'b0);
    rd(19, 0, 5100, 1'b0);

    start();
    feed(150, 1'b0, 7, 1'b0);
    START           = 1'b1;
    bus.pixel_in    = 8'd99;
    bus.pixel_valid = 1'b1;
    step();
    START           = 1'b0;
    bus.pixel_valid = 1'b0;
    check("collide_pix_rdy", 96'(bus.pixel_ready), 96'(1));
    rd(0, 0, 0, 1'b1);
    feed(400, 1'b0, 2, 1'b0);
    rd(19, 19, 800, 1'b0);
    rd(0, 0, 2, 1'b0);

    start();
    feed(200, 1'b0, 1, 1'b0);
    Reset_n = 1'b0;
    #1;
    check_outs_zero("midrst");
    step();
    Reset_n = 1'b1;
    step();
    rd(19, 19, 0, 1'b1);
    feed(3, 1'b0, 5, 1'b0);
    rd(0, 0, 0, 1'b1);

    start();
    feed(400, 1'b1, 0, 1'b1);
    check("ramp_frame", 96'(frame_ready), 96'(1));
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++)
        rd(x, y, ref_ii[y][x], 1'b0);

    repeat (3) step();
    check("drain", 96'(q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/integral_image_builder.md
INTEGRAL_IMAGE_BUILDER -- requirements
Module: integral_image_builder

Interface
REQ-001 Parameter IMG_W, default 20, meaning window width in pixels.
REQ-002 Parameter IMG_H, default 20, meaning window height in pixels.
REQ-003 Parameter PIX_W, default 8, meaning pixel bit width.
REQ-004 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 START  input  1  request to build a new integral image; sampled each cycle.
REQ-007 pixel_in  input  PIX_W  grayscale pixel, raster order (x fastest, then y).
REQ-008 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-009 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-010 x_in  input  5  read column, driven by the comparator's x_out.
REQ-011 y_in  input  5  read row, driven by the comparator's y_out.
REQ-012 rd_req  input  1  read request for II(x_in, y_in).
REQ-013 integral_buffer_out  output  96  read data: 17-bit integral value in [16:0], bits [95:17] zero.
REQ-014 rd_valid  output  1  integral_buffer_out and rd_err are valid this cycle.
REQ-015 rd_err  output  1  the returned read was rejected (not READY, or coordinates out of range).
REQ-016 frame_ready  output  1  a complete integral image is stored and readable.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUILD and READY.
REQ-018 Transitions: IDLE -START-> BUILD; BUILD -last pixel accepted-> READY; READY -START-> BUILD; BUILD -START-> BUILD with the pixel counter cleared.
REQ-019 pixel_ready SHALL be 1 only in BUILD; a pixel is accepted on a cycle with pixel_valid and pixel_ready both high.
REQ-020 An accepted pixel at (x,y) SHALL store II(x,y) = rowsum(x,y) + II(x,y-1), where rowsum is the running sum of row y up to and including x, and II(x,-1) = 0.
REQ-021 The row running sum SHALL reset to 0 at each x = 0; the x and y counters SHALL wrap x at IMG_W-1 and advance y.
REQ-022 Storage SHALL be IMG_W*IMG_H entries of 17 bits (max 20*20*255 = 102000); the arithmetic SHALL not saturate or overflow.
REQ-023 After the IMG_W*IMG_H-th accepted pixel, the FSM SHALL enter READY and frame_ready SHALL be 1 on the following cycle.
REQ-024 Read latency SHALL be 1 cycle: rd_req in cycle N gives rd_valid = 1 and the data in cycle N+1; rd_valid SHALL be a single-cycle pulse per request.
REQ-025 Back-to-back reads (rd_req high on consecutive cycles) SHALL each return data with no bubbles.
REQ-026 A read with x_in >= IMG_W or y_in >= IMG_H, or a read in any state other than READY, SHALL return data 0 with rd_err = 1.
REQ-027 If START and a valid pixel occur in the same BUILD cycle, START SHALL win and the pixel SHALL be discarded; pixel_ready SHALL stay 1.
REQ-028 START in READY SHALL clear frame_ready on the next cycle; a read issued in that same cycle SHALL still complete against the old image.
REQ-029 Pixels presented in IDLE or READY SHALL be ignored.

Reset
REQ-030 Reset_n low SHALL force IDLE and clear the counters and the row sum, and set pixel_ready, rd_valid, rd_err, frame_ready and integral_buffer_out to 0.
REQ-031 Storage contents need not be reset; they are unreadable until frame_ready is 1.
REQ-032 Reset asserted mid-BUILD SHALL abandon the frame; a new START is required.

Verification
REQ-033 START, then 400 pixels of value 1 -> frame_ready = 1; reads at (0,0), (4,2) and (19,19) return 1, 15 and 400, each with rd_err = 0.
REQ-034 START, then 400 pixels of value 255 -> read at (19,19) returns 102000, and read at (19,0) returns 5100.
REQ-035 Read at (20,3) in READY, and any read in IDLE -> rd_valid = 1, rd_err = 1, data 0.
REQ-036 START after 150 pixels, then 400 pixels of value 2 -> read at (19,19) returns 800.
REQ-037 Reset_n pulsed low after 200 pixels -> all outputs 0; a read returns rd_err = 1 until a full new frame completes.
REQ-038 Random pixel_valid gaps with a ramp image (value x+y) -> every II(x,y) matches the reference model over all 400 coordinates.
